process_aggregation: RTL
========================

Name: process_aggregation

Overview:
- Consumer of the aggregation flag (FLAG word, address 0x002) that the action-selection stage writes to node memory.
- On start, reads the flag; if it is set, sums the buffered packet words and writes the aggregate back to memory.
- Then clears the flag and signals done.
- Sits beside the action-selection stage on the same single-port node memory, under the same en/start/done sequencing.

Parameters:
- FLAG_ADDR, 11'h002, address of the forAggregation flag word.
- COUNT_ADDR, 11'h003, address of the buffered-packet count word.
- RESULT_ADDR, 11'h004, address where the aggregate sum is written.
- BUF_BASE, 11'h010, address of the first buffered packet word.
- MAX_PKTS, 32, clamp on the number of words aggregated.

Ports:
- clock  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  arm pulse; re-initialises the block while it is in S_WAIT_EN.
- start  in  1  begin pulse; sampled only in S_WAIT_START.
- data_in  in  16  memory read data.
- address  out  11  memory address.
- wr_en  out  1  memory write enable.
- data_out  out  16  memory write data.
- agg_sum  out  16  aggregate sum; saturates at 16'hFFFF.
- agg_count  out  16  number of words aggregated, after the clamp.
- agg_max  out  16  maximum word (see Optional Feature).
- agg_valid  out  1  high if the flag was set and an aggregation was performed in this run.
- done  out  1  run complete; held until the next en.

Behaviour:
- Reset:
  - rst=1 at any clock forces state S_WAIT_EN.
  - All outputs go to 0.
  - The internal index and accumulators clear.
  - A run in progress is abandoned; no further writes occur, and the memory flag is left as is.
- Registers:
  - All outputs are registered and updated on the edge that enters a state.
- Memory timing:
  - Synchronous RAM with 1-cycle latency.
  - data_in is sampled on the 2nd edge after the edge that drove address.
- States and transitions:
  - S_WAIT_EN: on en=1, clear done, agg_valid, agg_sum, agg_count, agg_max, address, data_out and wr_en; go to S_WAIT_START. start is ignored in this state.
  - S_WAIT_START: on start=1, set address=FLAG_ADDR and go to S_RD_FLAG. Otherwise hold.
  - S_RD_FLAG: go to S_WT_FLAG.
  - S_WT_FLAG: sample data_in.
    - If data_in[0]=0: go to S_DONE with done=1 and agg_valid=0; no writes.
    - Otherwise: set address=COUNT_ADDR and go to S_RD_CNT.
  - S_RD_CNT: go to S_WT_CNT.
  - S_WT_CNT: n = min(data_in, MAX_PKTS); agg_count=n; sum=0; idx=0.
    - If n=0: go to S_WR_RES.
    - Otherwise: set address=BUF_BASE and go to S_RD_BUF.
  - S_RD_BUF: go to S_WT_BUF.
  - S_WT_BUF: sum = sum + data_in, saturating (17-bit add; if bit 16 is set, result is 16'hFFFF); idx++.
    - If idx==n: go to S_WR_RES.
    - Otherwise: set address=BUF_BASE+idx and go to S_RD_BUF.
    - Cost is 2 cycles per word.
  - S_WR_RES: address=RESULT_ADDR, data_out=sum, wr_en=1, agg_sum=sum.
  - S_CLR_FLAG: address=FLAG_ADDR, data_out=16'h0, wr_en=1.
  - S_DONE: wr_en=0, done=1, agg_valid=1 (only when the flag was set); then go to S_WAIT_EN.
- Latency, counted from the edge that samples start (edge 0):
  - Flag clear: done high after edge 2.
  - Flag set: done high after edge 6+2n.
- wr_en is high for exactly 2 consecutive cycles per aggregation run: the result write, then the flag clear.
- Boundary conditions:
  - Count > MAX_PKTS: clamped, and agg_count reports the clamped value.
  - Count = 0: result 0 is written and the flag is still cleared.
  - en outside S_WAIT_EN: ignored.
  - start outside S_WAIT_START: ignored.
  - en and start asserted in the same cycle while in S_WAIT_EN: only en takes effect; start must be re-asserted.
  - Only data_in[0] of the flag word is tested.

Optional Feature:
- Macro: PROCESS_AGGREGATION_MAX_EN.
- Defined:
  - A running maximum of the buffered words is tracked alongside the sum.
  - State S_WR_MAX is inserted between S_WR_RES and S_CLR_FLAG: address=RESULT_ADDR+1, data_out=max, wr_en=1.
  - agg_max is set to the maximum.
  - wr_en is high for 3 cycles; flag-set latency becomes 7+2n.
  - For n=0, max=0.
- Undefined:
  - agg_max is tied to 0.
  - No S_WR_MAX state and no write to RESULT_ADDR+1.

Test Plan:
- Flag clear: mem[2]=0; rst, en, start → done=1 after edge 2, wr_en never asserted, agg_valid=0, mem[4] unchanged.
- Normal run: mem[2]=1, mem[3]=3, mem[16..18]=5,7,9 → mem[4]=21, mem[2]=0, agg_sum=21, agg_count=3, agg_valid=1, done after edge 12 (13 with MAX_EN, mem[5]=9).
- Saturation and clamp:
  - mem[3]=40, every buffer word 16'h1000 → agg_count=32, agg_sum=16'hFFFF, exactly 32 buffer reads (addresses 0x010–0x02F).
  - mem[3]=0 → mem[4]=0, mem[2] cleared, done after edge 6.
- Reset mid-run: rst=1 while in S_WT_BUF of a 3-word run → all outputs 0 next cycle, no write to 4 or 2, mem[2] still 1; a subsequent en+start completes normally.
- Handshake: start without a prior en, and start held in the same cycle as en → ignored (done stays 0); second en after done → done, agg_valid and agg_sum cleared.

Source files
------------

// File: rtl/process_aggregation_if.sv
// Node-memory bus plus en/start/done sequencing for process_aggregation.
// The block is the master of the single-port memory; the surrounding
// sequencer/memory environment uses the slave view.
interface process_aggregation_if;
  logic        en;
  logic        start;
  logic        done;
  logic [15:0] data_in;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] data_out;

  modport master (
    input  en,
    input  start,
    input  data_in,
    output address,
    output wr_en,
    output data_out,
    output done
  );

  modport slave (
    output en,
    output start,
    output data_in,
    input  address,
    input  wr_en,
    input  data_out,
    input  done
  );
endinterface

// File: rtl/process_aggregation.sv
// process_aggregation: consumes the forAggregation flag in node memory.
// On start it reads the flag word. If bit 0 is set, it reads the buffered
// packet count, sums up to MAX_PKTS buffered words with 16-bit saturation,
// writes the sum to RESULT_ADDR and then clears the flag.
// Optional feature macro: PROCESS_AGGREGATION_MAX_EN -- also tracks the
// maximum buffered word and writes it to RESULT_ADDR+1 before the flag clear.
// Every output is a flop loaded on the edge that enters the corresponding state.
module process_aggregation #(
  parameter logic [10:0] FLAG_ADDR   = 11'h002,
  parameter logic [10:0] COUNT_ADDR  = 11'h003,
  parameter logic [10:0] RESULT_ADDR = 11'h004,
  parameter logic [10:0] BUF_BASE    = 11'h010,
  parameter int unsigned MAX_PKTS    = 32
) (
  input  logic                   clock,
  input  logic                   rst,
  process_aggregation_if.master  bus,
  output logic [15:0]            agg_sum,
  output logic [15:0]            agg_count,
  output logic [15:0]            agg_max,
  output logic                   agg_valid
);

  localparam int IDX_W = $clog2(MAX_PKTS + 1);

  typedef enum logic [3:0] {
    S_WAIT_EN    = 4'd0,
    S_WAIT_START = 4'd1,
    S_RD_FLAG    = 4'd2,
    S_WT_FLAG    = 4'd3,
    S_RD_CNT     = 4'd4,
    S_WT_CNT     = 4'd5,
    S_RD_BUF     = 4'd6,
    S_WT_BUF     = 4'd7,
    S_WR_RES     = 4'd8,
    S_CLR_FLAG   = 4'd9,
    S_DONE       = 4'd10
`ifdef PROCESS_AGGREGATION_MAX_EN
    , S_WR_MAX   = 4'd11
`endif
  } state_e;

  // 17-bit add; any carry out pins the result at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] full;
    full = {1'b0, a} + {1'b0, b};
    if (full[16]) begin
      sat_add16 = 16'hFFFF;
    end else begin
      sat_add16 = full[15:0];
    end
  endfunction

  state_e           state_q,     state_d;
  logic [10:0]      address_q,   address_d;
  logic             wr_en_q,     wr_en_d;
  logic [15:0]      data_out_q,  data_out_d;
  logic [15:0]      agg_sum_q,   agg_sum_d;
  logic [15:0]      agg_count_q, agg_count_d;
  logic             agg_valid_q, agg_valid_d;
  logic             done_q,      done_d;
  logic [15:0]      sum_q,       sum_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [IDX_W-1:0] n_q,         n_d;
`ifdef PROCESS_AGGREGATION_MAX_EN
  logic [15:0]      max_q,       max_d;
  logic [15:0]      agg_max_q,   agg_max_d;
`endif

  // Next-state and next-output decode for the flag/count/buffer walk.
  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    wr_en_d     = wr_en_q;
    data_out_d  = data_out_q;
    agg_sum_d   = agg_sum_q;
    agg_count_d = agg_count_q;
    agg_valid_d = agg_valid_q;
    done_d      = done_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    n_d         = n_q;
`ifdef PROCESS_AGGREGATION_MAX_EN
    max_d       = max_q;
    agg_max_d   = agg_max_q;
`endif
    case (state_q)
      S_WAIT_EN: begin
        // start is deliberately not looked at here, even in the en cycle.
        if (bus.en) begin
          done_d      = 1'b0;
          agg_valid_d = 1'b0;
          agg_sum_d   = 16'h0000;
          agg_count_d = 16'h0000;
          address_d   = 11'h000;
          data_out_d  = 16'h0000;
          wr_en_d     = 1'b0;
`ifdef PROCESS_AGGREGATION_MAX_EN
          agg_max_d   = 16'h0000;
`endif
          state_d     = S_WAIT_START;
        end else begin
          state_d = S_WAIT_EN;
        end
      end
      S_WAIT_START: begin
        if (bus.start) begin
          address_d = FLAG_ADDR;
          state_d   = S_RD_FLAG;
        end else begin
          state_d = S_WAIT_START;
        end
      end
      S_RD_FLAG: state_d = S_WT_FLAG;
      S_WT_FLAG: begin
        if (bus.data_in[0]) begin
          address_d = COUNT_ADDR;
          state_d   = S_RD_CNT;
        end else begin
          done_d      = 1'b1;
          agg_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_RD_CNT: state_d = S_WT_CNT;
      S_WT_CNT: begin
        if (bus.data_in > 16'(MAX_PKTS)) begin
          n_d = IDX_W'(MAX_PKTS);
        end else begin
          n_d = bus.data_in[IDX_W-1:0];
        end
        agg_count_d = 16'(n_d);
        sum_d       = 16'h0000;
        idx_d       = '0;
`ifdef PROCESS_AGGREGATION_MAX_EN
        max_d       = 16'h0000;
`endif
        if (n_d == '0) begin
          // Empty buffer still produces a zero result write.
          address_d  = RESULT_ADDR;
          data_out_d = 16'h0000;
          wr_en_d    = 1'b1;
          agg_sum_d  = 16'h0000;
          state_d    = S_WR_RES;
        end else begin
          address_d = BUF_BASE;
          state_d   = S_RD_BUF;
        end
      end
      S_RD_BUF: state_d = S_WT_BUF;
      S_WT_BUF: begin
        sum_d = sat_add16(sum_q, bus.data_in);
        idx_d = idx_q + 1'b1;
`ifdef PROCESS_AGGREGATION_MAX_EN
        max_d = (bus.data_in > max_q) ? bus.data_in : max_q;
`endif
        if (idx_d == n_q) begin
          address_d  = RESULT_ADDR;
          data_out_d = sum_d;
          wr_en_d    = 1'b1;
          agg_sum_d  = sum_d;
          state_d    = S_WR_RES;
        end else begin
          address_d = BUF_BASE + 11'(idx_d);
          state_d   = S_RD_BUF;
        end
      end
      S_WR_RES: begin
`ifdef PROCESS_AGGREGATION_MAX_EN
        address_d  = RESULT_ADDR + 11'd1;
        data_out_d = max_q;
        wr_en_d    = 1'b1;
        agg_max_d  = max_q;
        state_d    = S_WR_MAX;
`else
        address_d  = FLAG_ADDR;
        data_out_d = 16'h0000;
        wr_en_d    = 1'b1;
        state_d    = S_CLR_FLAG;
`endif
      end
`ifdef PROCESS_AGGREGATION_MAX_EN
      S_WR_MAX: begin
        address_d  = FLAG_ADDR;
        data_out_d = 16'h0000;
        wr_en_d    = 1'b1;
        state_d    = S_CLR_FLAG;
      end
`endif
      S_CLR_FLAG: begin
        // Only reached when the flag was set, so the run is valid.
        wr_en_d     = 1'b0;
        done_d      = 1'b1;
        agg_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: state_d = S_WAIT_EN;
      default: begin
        wr_en_d = 1'b0;
        state_d = S_WAIT_EN;
      end
    endcase
  end

  // State and output registers; reset abandons any run without writing.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_WAIT_EN;
      address_q   <= 11'h000;
      wr_en_q     <= 1'b0;
      data_out_q  <= 16'h0000;
      agg_sum_q   <= 16'h0000;
      agg_count_q <= 16'h0000;
      agg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      sum_q       <= 16'h0000;
      idx_q       <= '0;
      n_q         <= '0;
`ifdef PROCESS_AGGREGATION_MAX_EN
      max_q       <= 16'h0000;
      agg_max_q   <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      wr_en_q     <= wr_en_d;
      data_out_q  <= data_out_d;
      agg_sum_q   <= agg_sum_d;
      agg_count_q <= agg_count_d;
      agg_valid_q <= agg_valid_d;
      done_q      <= done_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
`ifdef PROCESS_AGGREGATION_MAX_EN
      max_q       <= max_d;
      agg_max_q   <= agg_max_d;
`endif
    end
  end

  assign bus.address  = address_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.data_out = data_out_q;
  assign bus.done     = done_q;
  assign agg_sum      = agg_sum_q;
  assign agg_count    = agg_count_q;
  assign agg_valid    = agg_valid_q;
`ifdef PROCESS_AGGREGATION_MAX_EN
  assign agg_max      = agg_max_q;
`else
  assign agg_max      = 16'h0000;
`endif

endmodule
